// File: rtl/seg_scan_driver.sv
// Two-digit time-multiplexed seven-segment driver: double-buffered patterns,
// frame-boundary commit, dead time between digits, optional leading-zero blanking.
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       load,
    input  logic [6:0] seg1_in,
    input  logic [6:0] seg0_in,
    input  logic       blank_lz,
    output logic [6:0] seg_out,
    output logic [1:0] an,
    output logic       frame_tick,
    output logic       pending
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] R_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] B_LAST  = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0]    SEG_OFF = '1;
    localparam logic [6:0]    ZERO    = 7'b0000001;

    typedef enum logic [1:0] {BLANK1, SHOW1, BLANK0, SHOW0} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      shadow1_q, shadow1_d, shadow0_q, shadow0_d;
    logic [6:0]      disp1_q, disp1_d, disp0_q, disp0_d;
    logic            pending_q, pending_d;
    logic            tick_q, tick_d;
    logic [6:0]      seg_q, seg_d;
    logic [1:0]      an_q, an_d;
    logic            last, commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BLANK1;
            cnt_q     <= '0;
            shadow1_q <= SEG_OFF;
            shadow0_q <= SEG_OFF;
            disp1_q   <= SEG_OFF;
            disp0_q   <= SEG_OFF;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            seg_q     <= SEG_OFF;
            an_q      <= 2'b11;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow1_q <= shadow1_d;
            shadow0_q <= shadow0_d;
            disp1_q   <= disp1_d;
            disp0_q   <= disp0_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        commit  = 1'b0;
        tick_d  = 1'b0;
        last    = (state_q == SHOW1 || state_q == SHOW0) ? (cnt_q == R_LAST)
                                                         : (cnt_q == B_LAST);

        // While disabled the FSM parks at the start of BLANK1 and commits every cycle
        if (!enable) begin
            state_d = BLANK1;
            cnt_d   = '0;
            commit  = 1'b1;
        end else if (last) begin
            cnt_d = '0;
            unique case (state_q)
                BLANK1: state_d = SHOW1;
                SHOW1:  state_d = BLANK0;
                BLANK0: state_d = SHOW0;
                SHOW0: begin
                    state_d = BLANK1;
                    commit  = 1'b1;
                    tick_d  = 1'b1;
                end
                default: state_d = BLANK1;
            endcase
        end

        shadow1_d = load ? seg1_in : shadow1_q;
        shadow0_d = load ? seg0_in : shadow0_q;
        pending_d = commit ? 1'b0 : (load ? 1'b1 : pending_q);

        // A load on the commit edge bypasses the shadow so it is not lost
        disp1_d = disp1_q;
        disp0_d = disp0_q;
        if (commit) begin
            if (load) begin
                disp1_d = seg1_in;
                disp0_d = seg0_in;
            end else if (pending_q) begin
                disp1_d = shadow1_q;
                disp0_d = shadow0_q;
            end
        end

        an_d  = 2'b11;
        seg_d = SEG_OFF;
        unique case (state_d)
            SHOW1: begin
                if (!(blank_lz && disp1_d == ZERO)) begin
                    an_d  = 2'b01;
                    seg_d = disp1_d;
                end
            end
            SHOW0: begin
                an_d  = 2'b10;
                seg_d = disp0_d;
            end
            default: ;
        endcase
    end

    assign seg_out    = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (R=4, B=2): per-cycle expectations are
// pushed to a scoreboard queue before each edge and popped/checked after it.
module tb_seg_scan_driver;

    localparam int R     = 4;
    localparam int B     = 2;
    localparam int FRAME = 2 * (R + B);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg1_in = '1;
    logic [6:0] seg0_in = '1;
    logic [6:0] seg_out;
    logic [1:0] an;
    logic       frame_tick;
    logic       pending;

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .seg1_in    (seg1_in),
        .seg0_in    (seg0_in),
        .blank_lz   (blank_lz),
        .seg_out    (seg_out),
        .an         (an),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    typedef struct packed {
        logic [1:0] an;
        logic [6:0] seg;
        logic       tick;
        logic       pend;
    } exp_t;

    exp_t       sb[$];
    int         phase;
    logic [6:0] m_d1, m_d0, m_s1, m_s0;
    logic       m_pend;
    int         n_assert = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase  = 0;
        m_d1   = '1;
        m_d0   = '1;
        m_s1   = '1;
        m_s0   = '1;
        m_pend = 1'b0;
    endtask

    // One clock: drive stimulus, predict the post-edge outputs, then compare.
    task automatic cyc(input logic ld, input logic [6:0] s1, input logic [6:0] s0);
        exp_t e;
        logic commit, tick;
        load    = ld;
        seg1_in = s1;
        seg0_in = s0;
        commit  = !enable || (phase == FRAME - 1);
        tick    = enable && (phase == FRAME - 1);
        phase   = enable ? (phase + 1) % FRAME : 0;
        if (commit) begin
            if (ld) begin
                m_d1 = s1;
                m_d0 = s0;
            end else if (m_pend) begin
                m_d1 = m_s1;
                m_d0 = m_s0;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            m_s1   = s1;
            m_s0   = s0;
            m_pend = 1'b1;
        end
        e.an   = 2'b11;
        e.seg  = 7'h7F;
        e.tick = tick;
        e.pend = m_pend;
        if (phase >= B && phase < B + R) begin
            if (!(blank_lz && m_d1 == 7'b0000001)) begin
                e.an  = 2'b01;
                e.seg = m_d1;
            end
        end else if (phase >= 2 * B + R) begin
            e.an  = 2'b10;
            e.seg = m_d0;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("an",         {6'd0, an},         {6'd0, e.an});
        chk("seg_out",    {1'b0, seg_out},    {1'b0, e.seg});
        chk("frame_tick", {7'd0, frame_tick}, {7'd0, e.tick});
        chk("pending",    {7'd0, pending},    {7'd0, e.pend});
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '1, '1);
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < FRAME && phase != p; i++) cyc(1'b0, '1, '1);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_an"},   {6'd0, an},         8'h03);
        chk({tag, "_seg"},  {1'b0, seg_out},    8'h7F);
        chk({tag, "_tick"}, {7'd0, frame_tick}, 8'h00);
        chk({tag, "_pend"}, {7'd0, pending},    8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #12;
        chk_dark("reset");
        rst_n  = 1'b1;
        enable = 1'b1;

        // Idle scanning: blank buffers, ticks every frame
        idle(4 * FRAME);

        // "13" loaded mid-SHOW1, held in shadow until commit
        run_to(3);
        cyc(1'b1, 7'b1001111, 7'b0000110);
        idle(2 * FRAME);

        // "12" loaded while "13" is shown
        run_to(3);
        cyc(1'b1, 7'b1001111, 7'b0010010);
        idle(2 * FRAME);

        // "05", "07" in one frame, then "09" on the commit edge
        run_to(1);
        cyc(1'b1, 7'b0000001, 7'b0100100);
        run_to(6);
        cyc(1'b1, 7'b0000001, 7'b0001111);
        run_to(FRAME - 1);
        cyc(1'b1, 7'b0000001, 7'b0000100);
        idle(FRAME);

        // Leading-zero blanking on "05", then turned off
        blank_lz = 1'b1;
        run_to(4);
        cyc(1'b1, 7'b0000001, 7'b0100100);
        idle(2 * FRAME);
        blank_lz = 1'b0;
        idle(FRAME);

        // Asynchronous reset during SHOW0
        run_to(9);
        #2;
        rst_n = 1'b0;
        #1;
        chk_dark("rst_async");
        @(posedge clk);
        #1;
        chk_dark("rst_held");
        rst_n = 1'b1;
        model_reset();
        idle(2 * FRAME);
        run_to(3);
        cyc(1'b1, 7'b1001111, 7'b0000110);
        idle(2 * FRAME);

        // Disable with pending data, then re-enable
        run_to(3);
        cyc(1'b1, 7'b1001111, 7'b0010010);
        enable = 1'b0;
        idle(5);
        enable = 1'b1;
        idle(2 * FRAME);

        // Disable right at the commit edge: no tick
        run_to(FRAME - 1);
        enable = 1'b0;
        idle(3);
        enable = 1'b1;
        idle(FRAME + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
